spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- SPI mode-0 master that drives the reversible PE's SPI slave port from a simple command/response interface.
- A bench-side or FPGA-side controller uses it to load operand words, issue the START command and read back results.
- Generates spi_clk from the system clock, serialises one frame per command and returns read data.
- One frame at a time; no internal queueing.

Parameters:
- ADDR_W, 5, frame address field width (slave address width + 2).
- DATA_W, 18, frame data field width (payload 16 + command 2).
- CLK_DIV, 2, spi_clk half-period in clk cycles. Minimum 1; minimum 3 when SPI_MASTER_MISO_SYNC_EN is defined.
- RD_DUMMY, 2, spi_clk cycles inserted between address and data on reads so the slave can fetch rdata.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master can accept a command; high only in IDLE.
- cmd_rw  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  frame address.
- cmd_wdata  input  DATA_W  write data; ignored on reads.
- rsp_valid  output  1  one-cycle pulse when a frame completes.
- rsp_rdata  output  DATA_W  captured read data; 0 after a write.
- busy  output  1  high from command accept until the end of GAP.
- spi_clk  output  1  SPI clock, idles low.
- spi_csn  output  1  chip select, active low.
- spi_mosi  output  1  host to slave.
- spi_miso  input  1  slave to host.

Behaviour:
- Reset (rst_n low at a posedge clk):
  - State goes to IDLE.
  - spi_csn=1, spi_clk=0, spi_mosi=0, cmd_ready=1 (from the next cycle), rsp_valid=0, rsp_rdata=0, busy=0.
  - Reset mid-frame drops the frame with no rsp_valid; csn rises on that edge.
- Frame format, MSB-first on each field:
  - One rw bit, then ADDR_W address bits.
  - Reads: RD_DUMMY bits with mosi=0, then DATA_W data bits.
  - Writes: DATA_W data bits.
  - N = 1+ADDR_W+DATA_W for writes, N = 1+ADDR_W+RD_DUMMY+DATA_W for reads.
  - On reads mosi=0 during the data field.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready at a posedge clk.
  - The rw, addr and wdata fields are latched into a shift register.
  - cmd_ready drops on the next cycle.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
  - IDLE: csn=1, clk=0.
  - CS_SETUP: csn=0, lasts CLK_DIV cycles, mosi = first bit.
  - SHIFT: N bits. Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles. mosi updates at the start of each low phase, i.e. coincident with the spi_clk falling edge.
  - CS_HOLD: clk=0, csn=0, lasts CLK_DIV cycles.
  - GAP: csn=1, lasts 2*CLK_DIV cycles.
  - csn is low for exactly CLK_DIV*(2N+2) cycles.
- MISO capture:
  - Only during the DATA_W data bits of a read.
  - Bits are shifted in MSB-first into rd_shift. Dummy-bit miso is ignored.
- Response:
  - rsp_valid pulses on the first cycle of GAP.
  - rsp_rdata is updated on that same cycle and holds until the next response.
  - For a write, rsp_rdata=0.
- busy = !IDLE.
- cmd_valid asserted while busy is held off by cmd_ready=0; no loss and no overlap.
- The bit counter is sized for the maximum N; no wrap within a frame.

Optional Feature:
- Macro: SPI_MASTER_MISO_SYNC_EN.
- Defined:
  - spi_miso passes through a 2-flop synchroniser.
  - Each data bit is sampled 2 clk cycles after the spi_clk rising edge. This requires CLK_DIV>=3; elaboration fails otherwise.
- Undefined:
  - Raw spi_miso is sampled on the clk edge at which spi_clk goes high.
  - No synchroniser flops.
- Frame timing and rsp_valid timing are identical in both builds.

Test Plan:
- Reset with CLK_DIV=2: assert rst_n=0 for 3 cycles -> csn=1, spi_clk=0, mosi=0, busy=0, cmd_ready=1, rsp_valid=0.
- Write, addr=5'h03, wdata=18'h1_A5C3 (cmd 01): mosi stream 1,00011,01_1010_0101_1100_0011 across 24 bits; csn low 100 cycles; rsp_valid 1 cycle, rsp_rdata=0.
- Write of the START command (addr=0, wdata=18'h2_0000) followed back-to-back by a read of addr=5'h07:
  - Second command is stalled (cmd_ready=0) until GAP ends.
  - Gap with csn high is 4 cycles.
  - Read frame holds csn low for 108 cycles.
- Read where the slave model returns 18'h0_BEEF after 2 dummy bits -> rsp_rdata=18'h0_BEEF; dummy-bit miso=1 does not corrupt the result.
- Reset asserted at bit 10 of a write -> csn=1 on the next edge, no rsp_valid; a following read completes normally.
- Build with SPI_MASTER_MISO_SYNC_EN and CLK_DIV=3, read returning 18'h3_FFFF then 18'h0_0001 -> both captured exactly; csn low 6*(26+1)=162 cycles per read.

Source files
------------

// File: rtl/spi_host_master.sv
// SPI mode-0 master: one command in, one frame out, one response back.
// Define SPI_MASTER_MISO_SYNC_EN to add a 2-flop spi_miso synchroniser (needs CLK_DIV >= 3).
module spi_host_master #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 18,
    parameter int CLK_DIV  = 2,
    parameter int RD_DUMMY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_csn,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int NMAX   = 1 + ADDR_W + RD_DUMMY + DATA_W;
    localparam int NW     = 1 + ADDR_W + DATA_W;
    localparam int DSTART = 1 + ADDR_W + RD_DUMMY;
    localparam int BW     = $clog2(NMAX + 1);
    localparam int CW     = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic              high_q;
    logic              rw_q;
    logic              ready_q, busy_q, rsp_valid_q, sclk_q, csn_q, mosi_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [NMAX-1:0]   tx_q;
    logic [DATA_W-1:0] rd_q;

    logic phase_end, last_bit, next_bit, accept, sample, miso_bit;

    assign phase_end = (cnt_q == CW'(CLK_DIV - 1));
    assign last_bit  = (bit_q == (rw_q ? BW'(NW - 1) : BW'(NMAX - 1)));
    assign next_bit  = (state_q == SHIFT) && high_q && phase_end && !last_bit;
    assign accept    = (state_q == IDLE) && cmd_valid;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] sync_q;

    if (CLK_DIV < 3) begin : g_div_check
        $error("CLK_DIV must be >= 3 with the MISO synchroniser");
    end

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], spi_miso};
    end

    // Two clk cycles after spi_clk rises, the synchronised bit reflects the rising-edge value.
    assign sample   = (state_q == SHIFT) && high_q && (cnt_q == CW'(1));
    assign miso_bit = sync_q[1];
`else
    assign sample   = (state_q == SHIFT) && !high_q && phase_end;
    assign miso_bit = spi_miso;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_q <= cmd_rw ? {1'b1, cmd_addr, cmd_wdata, {RD_DUMMY{1'b0}}}
                           : {1'b0, cmd_addr, {(RD_DUMMY + DATA_W){1'b0}}};
        end else if (next_bit) begin
            tx_q <= {tx_q[NMAX-2:0], 1'b0};
        end
        if (sample && !rw_q && (bit_q >= BW'(DSTART))) begin
            rd_q <= {rd_q[DATA_W-2:0], miso_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            high_q      <= 1'b0;
            rw_q        <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sclk_q      <= 1'b0;
            csn_q       <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_q    <= cmd_rw;
                        csn_q   <= 1'b0;
                        mosi_q  <= cmd_rw;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        high_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        cnt_q <= '0;
                        if (!high_q) begin
                            high_q <= 1'b1;
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling edge: advance mosi to the next bit, or finish the frame.
                            high_q <= 1'b0;
                            sclk_q <= 1'b0;
                            if (last_bit) begin
                                mosi_q  <= 1'b0;
                                state_q <= CS_HOLD;
                            end else begin
                                bit_q  <= bit_q + BW'(1);
                                mosi_q <= tx_q[NMAX-2];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CS_HOLD: begin
                    if (phase_end) begin
                        cnt_q       <= '0;
                        csn_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rw_q ? '0 : rd_q;
                        state_q     <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign spi_clk   = sclk_q;
    assign spi_csn   = csn_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: slave model, frame/csn monitor and response scoreboard.
module tb_spi_host_master;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 18;
    localparam int RD_DUMMY = 2;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int CLK_DIV  = 3;
`else
    localparam int CLK_DIV  = 2;
`endif
    localparam int DSTART   = 1 + ADDR_W + RD_DUMMY;
    localparam int BUDGET   = 5000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              spi_clk;
    logic              spi_csn;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    spi_host_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .RD_DUMMY(RD_DUMMY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [63:0] frame;
        int          csn_len;
    } frm_t;

    frm_t              frm_q[$];
    logic [DATA_W-1:0] rsp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                low_cnt = 0;
    int                gap_cnt = 0;
    int                rx_bits = 0;
    logic [63:0]       rx_frame = '0;
    logic              in_frame = 1'b0;
    logic              aborted = 1'b0;
    logic              csn_prev = 1'b1;
    logic              sclk_prev = 1'b0;
    logic [DATA_W-1:0] slv_rdata = '0;

    // Slave drives data bits from slv_rdata and 1 everywhere else, so dummy/addr bits are poisoned.
    function automatic logic miso_for(int k);
        if (k >= DSTART && k < DSTART + DATA_W) return slv_rdata[DATA_W-1-(k-DSTART)];
        return 1'b1;
    endfunction

    // One clk cycle: sample everything on the falling clk edge, run slave model and scoreboard.
    task automatic tick();
        frm_t e;
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        if (spi_csn === 1'b0 && csn_prev === 1'b1) begin
            in_frame = 1'b1;
            rx_bits  = 0;
            rx_frame = '0;
            low_cnt  = 0;
        end
        if (spi_csn === 1'b0) low_cnt++;
        if (spi_csn === 1'b0 && spi_clk === 1'b1 && sclk_prev === 1'b0) begin
            rx_frame = {rx_frame[62:0], spi_mosi};
            rx_bits++;
        end
        if (spi_csn === 1'b0 && spi_clk === 1'b0 && (sclk_prev === 1'b1 || csn_prev === 1'b1))
            spi_miso = miso_for(rx_bits);
        if (spi_csn === 1'b1 && csn_prev === 1'b0 && in_frame) begin
            in_frame = 1'b0;
            gap_cnt  = 0;
            if (!aborted) begin
                checks++;
                if (frm_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got a frame of %0d bits, none expected", rx_bits);
                end else begin
                    e = frm_q.pop_front();
                    checks += 2;
                    if (rx_bits !== e.n) begin
                        errors++;
                        $display("FAIL frame_bits: got %0d required %0d", rx_bits, e.n);
                    end
                    if (rx_frame !== e.frame) begin
                        errors++;
                        $display("FAIL frame_mosi: got %h required %h", rx_frame, e.frame);
                    end
                    if (low_cnt !== e.csn_len) begin
                        errors++;
                        $display("FAIL csn_low_len: got %0d required %0d", low_cnt, e.csn_len);
                    end
                end
            end
        end
        if (spi_csn === 1'b1 && busy === 1'b1) gap_cnt++;
        if (rsp_valid === 1'b1) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid with rdata %h, none expected", rsp_rdata);
            end else begin
                exp = rsp_q.pop_front();
                if (rsp_rdata !== exp) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, exp);
                end
            end
        end
        csn_prev  = spi_csn;
        sclk_prev = spi_clk;
    endtask

    task automatic send_cmd(input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] sdata,
                            output int stall);
        frm_t e;
        logic r;
        e.n       = rw ? 1 + ADDR_W + DATA_W : 1 + ADDR_W + RD_DUMMY + DATA_W;
        e.frame   = rw ? {40'b0, 1'b1, addr, wdata} : {38'b0, 1'b0, addr, 20'b0};
        e.csn_len = CLK_DIV * (2 * e.n + 2);
        frm_q.push_back(e);
        rsp_q.push_back(rw ? '0 : sdata);
        slv_rdata = sdata;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        stall     = 0;
        forever begin
            r = cmd_ready;
            tick();
            if (r === 1'b1) break;
            stall++;
            if (stall >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: cmd_ready %b required 1", cmd_ready);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || rsp_q.size() != 0 || frm_q.size() != 0) && n < BUDGET) begin
            tick();
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %b pending rsp %0d required idle", busy, rsp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks += 7;
        if (spi_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b required 1", spi_csn); end
        if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", spi_clk); end
        if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b required 0", spi_mosi); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write();
        int stall;
        send_cmd(1'b1, 5'h03, 18'h1_A5C3, 18'h3_FFFF, stall);
        checks += 3;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL write_ready_drop: got %b required 0", cmd_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b required 1", busy); end
        if (spi_csn !== 1'b0) begin errors++; $display("FAIL write_csn_low: got %b required 0", spi_csn); end
        wait_idle();
        checks++;
        if (rsp_rdata !== '0) begin errors++; $display("FAIL write_rdata_hold: got %h required 0", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int stall;
        send_cmd(1'b1, 5'h00, 18'h2_0000, 18'h0, stall);
        send_cmd(1'b0, 5'h07, 18'h3_1234, 18'h1_2345, stall);
        checks += 2;
        if (stall !== CLK_DIV * (2 * (1 + ADDR_W + DATA_W) + 4)) begin
            errors++;
            $display("FAIL b2b_stall: got %0d required %0d", stall, CLK_DIV * (2 * (1 + ADDR_W + DATA_W) + 4));
        end
        if (gap_cnt !== 2 * CLK_DIV) begin
            errors++;
            $display("FAIL b2b_gap: got %0d required %0d", gap_cnt, 2 * CLK_DIV);
        end
        wait_idle();
    endtask

    task automatic test_read();
        int stall;
        send_cmd(1'b0, 5'h0A, 18'h2_AAAA, 18'h0_BEEF, stall);
        wait_idle();
        checks++;
        if (rsp_rdata !== 18'h0_BEEF) begin errors++; $display("FAIL read_rdata_hold: got %h required 0beef", rsp_rdata); end
        send_cmd(1'b0, 5'h1F, 18'h0, 18'h3_FFFF, stall);
        wait_idle();
        send_cmd(1'b0, 5'h10, 18'h0, 18'h0_0001, stall);
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        int stall;
        int n = 0;
        frm_t drop_f;
        logic [DATA_W-1:0] drop_r;
        send_cmd(1'b1, 5'h0C, 18'h1_5555, 18'h0, stall);
        while (rx_bits < 10 && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (rx_bits !== 10) begin errors++; $display("FAIL midframe_reach_bit10: got %0d required 10", rx_bits); end
        drop_f  = frm_q.pop_back();
        drop_r  = rsp_q.pop_back();
        aborted = 1'b1;
        rst_n   = 1'b0;
        tick();
        checks += 4;
        if (spi_csn !== 1'b1) begin errors++; $display("FAIL midframe_csn: got %b required 1", spi_csn); end
        if (spi_clk !== 1'b0) begin errors++; $display("FAIL midframe_sclk: got %b required 0", spi_clk); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %b required 0", busy); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midframe_rsp_valid: got %b required 0", rsp_valid); end
        rst_n = 1'b1;
        tick();
        aborted = 1'b0;
        repeat (4 * CLK_DIV) tick();
        send_cmd(1'b0, 5'h15, 18'h0, 18'h2_AAAA, stall);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
